// File: rtl/food_map_scanner.sv
// Food map port-B reader: fetches one tile row per scanline during h-blank,
// renders the pellet dot, and tallies remaining pellets once per frame.
module food_map_scanner #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int TILE_SHIFT = 3,
  parameter int DOT_LO     = 3,
  parameter int DOT_HI     = 4,
  parameter int RD_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [5:0]  food_map_read_y,
  input  logic [79:0] food_row,
  output logic        food_pixel,
  output logic [12:0] food_remaining,
  output logic        all_eaten,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [10:0] X_TRIG = 11'(H_ACTIVE);
  localparam logic [9:0]  Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [TILE_SHIFT-1:0] DLO = TILE_SHIFT'(DOT_LO);
  localparam logic [TILE_SHIFT-1:0] DHI = TILE_SHIFT'(DOT_HI);
  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, COUNT} state_t;

  state_t       state_reg;
  logic [79:0]  row_buf_reg;
  logic [12:0]  acc_reg;
  logic         count_row_reg;
  logic [3:0]   count_k_reg;
  logic [WCW-1:0] wait_cnt_reg;

  logic [9:0]   ny;
  logic         trig_hit;
  logic [6:0]   tile_x;
  logic         dot_x;
  logic         dot_y;
  logic         pixel_next;
  logic [9:0][3:0] byte_pop;

  function automatic logic [3:0] pop8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int b = 0; b < 8; b++) s = s + {3'b000, v[b]};
    return s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_pop
      assign byte_pop[gi] = pop8(row_buf_reg[gi*8 +: 8]);
    end
  endgenerate

  assign ny       = (pixel_y == Y_LAST) ? 10'd0 : pixel_y + 10'd1;
  assign trig_hit = (pixel_x == X_TRIG);
  assign tile_x   = pixel_x[TILE_SHIFT +: 7];
  assign dot_x    = (pixel_x[TILE_SHIFT-1:0] >= DLO) && (pixel_x[TILE_SHIFT-1:0] <= DHI);
  assign dot_y    = (pixel_y[TILE_SHIFT-1:0] >= DLO) && (pixel_y[TILE_SHIFT-1:0] <= DHI);
  // tile_x is only meaningful inside the active area, so the range test gates the lookup
  assign pixel_next = (pixel_x < X_TRIG) && (pixel_y < Y_ACT) &&
                      row_buf_reg[tile_x] && dot_x && dot_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      row_buf_reg     <= '0;
      acc_reg         <= '0;
      count_row_reg   <= 1'b0;
      count_k_reg     <= '0;
      wait_cnt_reg    <= '0;
      food_map_read_y <= '0;
      food_pixel      <= 1'b0;
      food_remaining  <= '0;
      all_eaten       <= 1'b0;
      frame_done      <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      food_pixel <= pixel_next;
      if (trig_hit && state_reg != IDLE) overrun <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (trig_hit) begin
            if (ny < Y_ACT) begin
              food_map_read_y <= ny[TILE_SHIFT +: 6];
              count_row_reg   <= (ny[TILE_SHIFT-1:0] == '0);
              state_reg       <= FETCH;
            end else if (ny == Y_ACT) begin
              // End of visible frame: publish the tally and start a fresh one
              food_remaining <= acc_reg;
              all_eaten      <= (acc_reg == 13'd0);
              frame_done     <= 1'b1;
              acc_reg        <= '0;
            end
          end
        end
        FETCH: begin
          wait_cnt_reg <= WCW'(RD_LAT - 1);
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_reg == '0) begin
            row_buf_reg <= food_row;
            count_k_reg <= '0;
            state_reg   <= count_row_reg ? COUNT : IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        COUNT: begin
          acc_reg <= acc_reg + {9'b0, byte_pop[count_k_reg]};
          if (count_k_reg == 4'd9) state_reg <= IDLE;
          else count_k_reg <= count_k_reg + 4'd1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/food_map_scanner.md
Name: food_map_scanner

Overview:
- Read-side client of the food map's port B; the pellet clear/write side lives on port A.
- Fetches one 80-bit food row per scanline during horizontal blanking and holds it in a row buffer.
- Renders a per-pixel pellet dot for the video mux.
- Sequentially popcounts each tile row once per frame and publishes the remaining-pellet total and a level-clear flag.

Parameters:
- H_ACTIVE, 640, visible pixels per line; the fetch trigger fires at pixel_x == H_ACTIVE.
- V_ACTIVE, 480, visible lines per frame.
- V_TOTAL, 525, total lines per frame including blanking.
- TILE_SHIFT, 3, log2 of the tile size in pixels (8x8 tiles, 80x60 tile grid).
- DOT_LO, 3, first in-tile pixel offset of the pellet dot (x and y).
- DOT_HI, 4, last in-tile pixel offset of the pellet dot (x and y).
- RD_LAT, 1, food map port B read latency in cycles.

Ports:
- clk  in  1  system/pixel clock; also drives food map port B (food_map_clk).
- rst_n  in  1  asynchronous active-low reset.
- pixel_x  in  11  current scan x.
- pixel_y  in  10  current scan y.
- food_map_read_y  out  6  port B row address.
- food_row  in  80  port B read data; bit n = column n, 1 = pellet present.
- food_pixel  out  1  pellet dot at the pixel presented one cycle earlier.
- food_remaining  out  13  pellet total from the last completed frame.
- all_eaten  out  1  high when the last committed total is 0.
- frame_done  out  1  one-cycle pulse when food_remaining/all_eaten update.
- overrun  out  1  sticky; a fetch trigger arrived while not IDLE.

Behaviour:
- Reset values: all outputs 0; row_buf 0; accumulator 0; state IDLE.
- all_eaten stays 0 until the first frame_done, even though food_remaining is 0 at reset.
- Next line: ny = (pixel_y == V_TOTAL-1) ? 0 : pixel_y+1.
- Trigger: the cycle where pixel_x == H_ACTIVE and state == IDLE.
- Trigger with ny < V_ACTIVE:
  - Register food_map_read_y <= ny >> TILE_SHIFT.
  - count_row <= (ny[TILE_SHIFT-1:0] == 0).
  - Go to FETCH.
- Trigger with ny == V_ACTIVE:
  - food_remaining <= accumulator.
  - all_eaten <= (accumulator == 0).
  - frame_done pulses for one cycle (the cycle after the trigger).
  - Accumulator cleared.
  - No fetch; remain in IDLE.
- Trigger with any other ny: no action.
- Trigger seen while state != IDLE: ignored; overrun set to 1 and held until reset.
- FSM:
  - IDLE: wait for trigger.
  - FETCH (1 cycle): address stable.
  - WAIT (RD_LAT cycles): wait for read data.
  - On WAIT exit: row_buf <= food_row.
  - If count_row: go to COUNT with k = 0. Otherwise: go to IDLE.
  - COUNT (10 cycles, k = 0..9): accumulator += popcount(row_buf[8k+7:8k]); after k == 9, go to IDLE.
- food_map_read_y holds its value from FETCH until the next trigger.
- Timing from trigger cycle T: read_y valid at T+1; row_buf updated at the end of T+1+RD_LAT; counting finishes by T+12+RD_LAT. All of this completes within horizontal blanking.
- food_pixel (registered) <= (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE) && row_buf[pixel_x >> TILE_SHIFT] && (pixel_x[TILE_SHIFT-1:0] in [DOT_LO, DOT_HI]) && (pixel_y[TILE_SHIFT-1:0] in [DOT_LO, DOT_HI]).
- Row n of the frame is displayed from data fetched during line n-1's blanking. Line 0 is fetched at line V_TOTAL-1 (wrap).
- Accumulator width is 13 bits; the maximum is 60*80 = 4800, so no saturation is needed.
- Asynchronous reset mid-COUNT: the partial accumulator is discarded. The first post-reset frame total may be partial; the next full frame is exact.
- Port A writes may land between a fetch and its display. This is accepted: the change shows at most one line late and counts in the next frame.

Test Plan:
1. Assert rst_n low mid-COUNT -> all outputs 0 immediately, state IDLE; after release, the first trigger fetches normally.
2. pixel_y=7, pixel_x=640 -> food_map_read_y=1 at T+1; count_row=1; 10 COUNT cycles observed.
3. Model all rows = all ones; present (43,44) -> food_pixel=1 next cycle; present (40,44) -> 0; present (43,47) -> 0; present (700,44) -> 0.
4. Full frame, rows 0-59 all ones -> frame_done pulse one cycle after pixel_y=479, pixel_x=640; food_remaining=4800, all_eaten=0.
5. Full frame, all rows zero -> food_remaining=0, all_eaten=1. Then set row 10 to 80'h1 (column 0 only) -> next frame food_remaining=1, all_eaten=0.
6. pixel_y=524, pixel_x=640 -> food_map_read_y=0. Force pixel_x=640 again during COUNT -> overrun=1, food_map_read_y unchanged.
